pid_channel_scheduler: RTL and testbench

PID_CHANNEL_SCHEDULER -- requirements
Module: pid_channel_scheduler

---
 rtl/pid_sched_pkg.sv | 31 +++
 rtl/pid_rr_arbiter.sv | 48 ++++
 rtl/pid_channel_scheduler.sv | 178 +++++++++++++++++
 tb/tb_pid_channel_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_sched_pkg.sv
// Shared types, widths and saturation limits for the multi-channel PID scheduler.
// Used by pid_channel_scheduler and pid_rr_arbiter.
package pid_sched_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_ERR   = 3'd2;
    localparam state_t ST_TERMS = 3'd3;
    localparam state_t ST_OUT   = 3'd4;
    localparam state_t ST_WB    = 3'd5;

    localparam int IW = 16;
    localparam int SW = 26;

    localparam logic signed [SW-1:0] INT_MAX = 26'sd32767;
    localparam logic signed [SW-1:0] INT_MIN = -26'sd32768;

    function automatic logic signed [IW-1:0] sat_int(
        input logic signed [SW-1:0] v
    );
        if (v > INT_MAX)
            return INT_MAX[IW-1:0];
        else if (v < INT_MIN)
            return INT_MIN[IW-1:0];
        else
            return v[IW-1:0];
    endfunction

endpackage

// File: rtl/pid_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last accepted grant.
// The pointer only moves when the grant is accepted.
module pid_rr_arbiter
    import pid_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req,
    input  logic           accept,
    output logic [NCH-1:0] grant,
    output logic [CW-1:0]  grant_idx
);

    logic [CW-1:0] ptr;
    logic [CW-1:0] jj;
    logic          found;
    int            j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        jj        = '0;
        for (int k = 0; k < NCH; k++) begin
            j = int'(ptr) + k;
            if (j >= NCH)
                j = j - NCH;
            jj = CW'(j);
            if (!found && req[jj]) begin
                found     = 1'b1;
                grant[jj] = 1'b1;
                grant_idx = jj;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (accept)
            ptr <= (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + CW'(1);
    end

endmodule

// File: rtl/pid_channel_scheduler.sv
// Time-multiplexed PID datapath shared by NCH channels, one update per 6 cycles.
// Define PID_SCHED_ANTIWINDUP_EN to suppress integral writeback while clamped.
module pid_channel_scheduler
    import pid_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           ch_req,
    input  logic [NCH-1:0]           ch_clr,
    input  logic [NCH*DW-1:0]        setpoint_flat,
    input  logic [NCH*DW-1:0]        feedback_flat,
    input  logic [7:0]               kp,
    input  logic [7:0]               ki,
    input  logic [7:0]               kd,
    output logic                     out_valid,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic [DW-1:0]            out_data,
    output logic                     busy
);

    localparam int CW = $clog2(NCH);
    localparam logic signed [SW-1:0] OUT_MAX = SW'((1 << DW) - 1);

    state_t                 state;
    logic [NCH-1:0]         pending, req_all, grant, grant_eff;
    logic [CW-1:0]          grant_idx, cur;
    logic                   accept;
    logic [DW-1:0]          sp, fb;
    logic [7:0]             kp_r, ki_r, kd_r;
    logic signed [IW-1:0]   integ, prev, err, deriv, integ_wr;
    logic signed [IW-1:0]   integ_mem [NCH];
    logic signed [IW-1:0]   prev_mem  [NCH];
    logic signed [SW-1:0]   kp_s, ki_s, kd_s, err_s, der_s, int_s;
    logic signed [SW-1:0]   int_raw, sum;
    logic [DW-1:0]          clamp_val;

    assign req_all   = pending | ch_req;
    assign accept    = (state == ST_IDLE) && (|req_all);
    assign grant_eff = grant & {NCH{accept}};
    assign busy      = (state != ST_IDLE);

    pid_rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_all),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign kp_s    = $signed(SW'(kp_r));
    assign ki_s    = $signed(SW'(ki_r));
    assign kd_s    = $signed(SW'(kd_r));
    assign err_s   = SW'(err);
    assign der_s   = SW'(deriv);
    assign int_s   = SW'(integ);
    assign int_raw = int_s + ki_s * err_s;
    assign sum     = kp_s * err_s + (int_s >>> 8) + kd_s * der_s;

    always_comb begin
        clamp_val = sum[DW-1:0];
        if (sum < 0)
            clamp_val = '0;
        else if (sum > OUT_MAX)
            clamp_val = '1;
    end

`ifdef PID_SCHED_ANTIWINDUP_EN
    logic                 clamp_hi, clamp_lo;
    logic signed [IW-1:0] integ_old;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clamp_hi  <= 1'b0;
            clamp_lo  <= 1'b0;
            integ_old <= '0;
        end else begin
            if (state == ST_LOAD)
                integ_old <= integ_mem[cur];
            if (state == ST_OUT) begin
                clamp_hi <= (sum > OUT_MAX);
                clamp_lo <= (sum < 0);
            end
        end
    end

    // Freeze the integral only while it pushes further into the clamp.
    assign integ_wr = ((clamp_hi && !err[IW-1] && err != '0) ||
                       (clamp_lo && err[IW-1])) ? integ_old : integ;
`else
    assign integ_wr = integ;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pending   <= '0;
            cur       <= '0;
            sp        <= '0;
            fb        <= '0;
            kp_r      <= '0;
            ki_r      <= '0;
            kd_r      <= '0;
            integ     <= '0;
            prev      <= '0;
            err       <= '0;
            deriv     <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else begin
            // A request consumed by its own grant is not queued again.
            pending <= (pending & ~grant_eff) |
                       (ch_req & ~(grant_eff & ~pending));
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cur   <= grant_idx;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    sp    <= setpoint_flat[int'(cur)*DW +: DW];
                    fb    <= feedback_flat[int'(cur)*DW +: DW];
                    integ <= integ_mem[cur];
                    prev  <= prev_mem[cur];
                    kp_r  <= kp;
                    ki_r  <= ki;
                    kd_r  <= kd;
                    state <= ST_ERR;
                end
                ST_ERR: begin
                    err   <= $signed(IW'(sp)) - $signed(IW'(fb));
                    state <= ST_TERMS;
                end
                ST_TERMS: begin
                    integ <= sat_int(int_raw);
                    deriv <= err - prev;
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    out_data  <= clamp_val;
                    out_ch    <= cur;
                    out_valid <= 1'b1;
                    state     <= ST_WB;
                end
                ST_WB: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                integ_mem[i] <= '0;
                prev_mem[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_clr[i]) begin
                    integ_mem[i] <= '0;
                    prev_mem[i]  <= '0;
                end else if (state == ST_WB && cur == CW'(i)) begin
                    integ_mem[i] <= integ_wr;
                    prev_mem[i]  <= err;
                end
            end
        end
    end

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// Scoreboard bench for pid_channel_scheduler: a PID reference model predicts
// every result, order and arrival cycle; a monitor checks each out_valid pulse.
module tb_pid_channel_scheduler;

    localparam int NCH = 4;
    localparam int DW  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    ch_req, ch_clr;
    logic [NCH*DW-1:0] setpoint_flat, feedback_flat;
    logic [7:0]        kp, ki, kd;
    logic              out_valid;
    logic [1:0]        out_ch;
    logic [DW-1:0]     out_data;
    logic              busy;

    pid_channel_scheduler #(.NCH(NCH), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ch_req        (ch_req),
        .ch_clr        (ch_clr),
        .setpoint_flat (setpoint_flat),
        .feedback_flat (feedback_flat),
        .kp            (kp),
        .ki            (ki),
        .kd            (kd),
        .out_valid     (out_valid),
        .out_ch        (out_ch),
        .out_data      (out_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int ch;
        int data;
        int at;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   m_int[NCH];
    int   m_prev[NCH];
    int   ptr;
    int   last_data;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_int[i]  = 0;
            m_prev[i] = 0;
        end
        ptr = 0;
    endfunction

    // One PID update on plain integers; returns the clamped output.
    function automatic int model_update(input int c, input bit clr);
        int sp, fb, e, i, d, s, o;
        sp = int'(setpoint_flat[c*DW +: DW]);
        fb = int'(feedback_flat[c*DW +: DW]);
        e  = sp - fb;
        i  = m_int[c] + int'(ki) * e;
        if (i > 32767)  i = 32767;
        if (i < -32768) i = -32768;
        d  = e - m_prev[c];
        s  = int'(kp) * e + (i >>> 8) + int'(kd) * d;
        o  = (s < 0) ? 0 : (s > 255) ? 255 : s;
`ifdef PID_SCHED_ANTIWINDUP_EN
        if ((s > 255 && e > 0) || (s < 0 && e < 0))
            i = m_int[c];
`endif
        m_int[c]  = clr ? 0 : i;
        m_prev[c] = clr ? 0 : e;
        return o;
    endfunction

    task automatic set_ch(input int c, input int sp, input int fb);
        setpoint_flat[c*DW +: DW] = DW'(sp);
        feedback_flat[c*DW +: DW] = DW'(fb);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            last_data = int'(out_data);
            if (q.size() == 0) begin
                check("unexpected out_valid", 1, 0);
            end else begin
                mon_e = q.pop_front();
                check("out_ch", int'(out_ch), mon_e.ch);
                check("out_data", int'(out_data), mon_e.data);
                check("valid cycle", cyc, mon_e.at);
                check("busy in WB", int'(busy), 1);
            end
        end
    end

    // Pulse ch_req from IDLE; optionally clear clr_ch during its WRITEBACK.
    task automatic run_batch(input logic [NCH-1:0] mask, input int clr_ch);
        int start, n, c, last;
        @(negedge clk);
        ch_req = mask;
        start  = cyc;
        n      = 0;
        last   = ptr;
        for (int k = 0; k < NCH; k++) begin
            c = (ptr + k) % NCH;
            if (mask[c]) begin
                q.push_back('{c, model_update(c, c == clr_ch), start + 5 + 6 * n});
                n++;
                last = c;
            end
        end
        ptr = (last + 1) % NCH;
        @(negedge clk);
        ch_req = '0;
        if (clr_ch >= 0) begin
            repeat (4) @(negedge clk);
            ch_clr[clr_ch] = 1'b1;
            @(negedge clk);
            ch_clr = '0;
        end
        for (int t = 0; t < 80 && q.size() > 0; t++)
            @(negedge clk);
        if (q.size() != 0) begin
            check("drain timeout", q.size(), 0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int c;
        logic [NCH-1:0] m;
        rst_n = 1'b0;
        ch_req = '0;
        ch_clr = '0;
        setpoint_flat = '0;
        feedback_flat = '0;
        kp = '0;
        ki = '0;
        kd = '0;
        last_data = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_ch", int'(out_ch), 0);
        check("reset out_data", int'(out_data), 0);
        check("reset busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        kp = 8'd2;
        set_ch(0, 100, 40);
        run_batch(4'b0001, -1);
        set_ch(0, 200, 10);
        run_batch(4'b0001, -1);
        set_ch(0, 10, 200);
        run_batch(4'b0001, -1);

        kp = 8'd1; ki = 8'd3; kd = 8'd2;
        for (int i = 0; i < NCH; i++)
            set_ch(i, $urandom_range(0, 255), $urandom_range(0, 255));
        run_batch(4'b1111, -1);
        run_batch(4'b1010, -1);

        kp = 8'd0; ki = 8'd50; kd = 8'd1;
        set_ch(2, 200, 100);
        run_batch(4'b0100, -1);
        run_batch(4'b0100, 2);
        run_batch(4'b0100, -1);

        // Abort an update in CALC_TERMS.
        @(negedge clk);
        ch_req = 4'b0010;
        @(negedge clk);
        ch_req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", int'(out_valid), 0);
        check("abort out_ch", int'(out_ch), 0);
        check("abort out_data", int'(out_data), 0);
        check("abort busy", int'(busy), 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        kp = 8'd1; ki = 8'd20; kd = 8'd1;
        run_batch(4'b0110, -1);

        kp = 8'd0; ki = 8'd255; kd = 8'd0;
        set_ch(0, 255, 0);
        for (int i = 0; i < 600; i++)
            run_batch(4'b0001, -1);
        check("integral saturation out", last_data, 127);

        kp = 8'd2; ki = 8'd16; kd = 8'd0;
        set_ch(3, 200, 0);
        for (int i = 0; i < 5; i++)
            run_batch(4'b1000, -1);
        kp = 8'd0; ki = 8'd0;
        run_batch(4'b1000, -1);

        for (int b = 0; b < 150; b++) begin
            m = NCH'($urandom_range(1, 15));
            for (int i = 0; i < NCH; i++)
                set_ch(i, $urandom_range(0, 255), $urandom_range(0, 255));
            kp = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            ki = 8'($urandom_range(0, 40));
            kd = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                c = $urandom_range(0, NCH - 1);
                @(negedge clk);
                ch_clr[c] = 1'b1;
                @(negedge clk);
                ch_clr = '0;
                m_int[c]  = 0;
                m_prev[c] = 0;
            end
            run_batch(m, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
